// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the two-requester adder-sharing arbiter.
package adder_share_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_ADD_LAT = 1;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester always wins, a contested
// grant goes to whichever requester was not served last.
module rr_arbiter2
   import adder_share_arbiter_pkg::*;
(
   input  logic       i_valid0,
   input  logic       i_valid1,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   assign o_grant[0] = i_valid0 && (!i_valid1 || (i_last_grant == REQ1));
   assign o_grant[1] = i_valid1 && (!i_valid0 || (i_last_grant == REQ0));

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates two requesters onto one shared adder: latch operands, hold them
// for ADD_LAT cycles, capture the sum+carry and return it tagged with the owner.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_cin,
   output logic             add_start,
   input  logic [WIDTH:0]   add_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH:0]   rsp_result,
   output state_t           o_dbg_state
);

   localparam int             CW    = $clog2(ADD_LAT + 1);
   localparam logic [CW-1:0]  LAT_C = CW'(ADD_LAT);

   state_t            r_state;
   logic              r_last_grant;
   logic [CW-1:0]     r_cnt;
   logic [WIDTH-1:0]  r_add_a;
   logic [WIDTH-1:0]  r_add_b;
   logic              r_add_cin;
   logic              r_add_start;
   logic              r_rsp_valid;
   logic              r_rsp_id;
   logic [WIDTH:0]    r_rsp_result;
   logic [1:0]        w_grant;
   logic              w_accept;

   rr_arbiter2 u_arb (
      .i_valid0     (req0_valid),
      .i_valid1     (req1_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   // Grant implies valid, so ready already carries the "only while valid" rule.
   // rst_n gating keeps ready low while reset is held.
   assign req0_ready = rst_n && (r_state == IDLE) && w_grant[0];
   assign req1_ready = rst_n && (r_state == IDLE) && w_grant[1];
   assign w_accept   = req0_ready || req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= REQ1;
         r_cnt        <= '0;
         r_add_a      <= '0;
         r_add_b      <= '0;
         r_add_cin    <= 1'b0;
         r_add_start  <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= REQ0;
         r_rsp_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_add_a      <= req1_ready ? req1_a   : req0_a;
                  r_add_b      <= req1_ready ? req1_b   : req0_b;
                  r_add_cin    <= req1_ready ? req1_cin : req0_cin;
                  r_last_grant <= req1_ready;
                  r_rsp_id     <= req1_ready;
                  r_cnt        <= CW'(1);
                  r_add_start  <= 1'b1;
                  r_state      <= CALC;
               end
            end
            CALC: begin
               r_add_start <= 1'b0;
               if (r_cnt == LAT_C) begin
                  r_rsp_result <= add_result;
                  r_rsp_valid  <= 1'b1;
                  r_state      <= RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cnt       <= '0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign add_a       = r_add_a;
   assign add_b       = r_add_b;
   assign add_cin     = r_add_cin;
   assign add_start   = r_add_start;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_result  = r_rsp_result;
   assign o_dbg_state = r_state;

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit carry-select adder datapath between two requesters; round-robin grant, valid/ready on both sides.
- Latches the granted operands, holds them stable on the adder inputs for ADD_LAT cycles, captures the (WIDTH+1)-bit sum+carry and returns it tagged with the requester ID.
- Sits between the lab's operand sources and the shared adder/result-select datapath; it is the only driver of the adder inputs.

Parameters:
- WIDTH, 32, operand width; result is WIDTH+1 bits with carry-out as the MSB.
- ADD_LAT, 1, adder latency in cycles, legal range 1..8. 1 = combinational adder; 2 = adder with one output register.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid  in  1  requester 0 has operands.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0.
- add_a, add_b  out  WIDTH  operands to the shared adder, registered.
- add_cin  out  1  carry-in to the shared adder, registered.
- add_start  out  1  one-cycle pulse marking new operands.
- add_result  in  WIDTH+1  adder sum; bit WIDTH is carry-out.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH+1  captured sum.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, last_grant=1 so requester 0 wins the first contested grant, latency counter=0.
  - All outputs 0: req*_ready, add_a, add_b, add_cin, add_start, rsp_valid, rsp_id, rsp_result.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - req*_ready is combinational. It is high only for the granted requester, and only while that requester's valid is high.
  - Grant: if only one valid is high, grant it. If both are high, grant the requester that is not last_grant.
  - On a handshake (valid&&ready): latch a, b, cin into the add_* registers; set last_grant and rsp_id to the winner; counter=1; go to CALC.
  - Dropping valid without a handshake is legal: no grant, no state change.
- CALC:
  - add_start is high in the first CALC cycle only.
  - add_a, add_b and add_cin are held constant through CALC.
  - Both req*_ready stay low.
  - Counter increments each cycle. At the edge ending CALC cycle ADD_LAT: rsp_result<=add_result, go to RESP.
- RESP:
  - rsp_valid is high. rsp_result and rsp_id are stable until the handshake.
  - Both req*_ready stay low, so backpressure from rsp_ready=0 blocks new grants indefinitely.
  - On rsp_valid&&rsp_ready: go to IDLE next cycle. There is no same-cycle re-accept (one bubble cycle).
- Latency: accept in cycle 0 -> rsp_valid first high in cycle ADD_LAT+1. Throughput is one operation per ADD_LAT+2 cycles.
- Arithmetic: no truncation. Carry-out is passed through in rsp_result[WIDTH]; wrap-around is visible only as bit WIDTH.
- Counter width is $clog2(ADD_LAT+1). The counter never exceeds ADD_LAT.
- Reset mid-CALC or mid-RESP: the transaction is discarded, rsp_valid drops at once, and the arbiter restarts with requester 0 priority.
- req*_ready depends only on state, valid and last_grant, never on rsp_ready, so there is no combinational loop.

Decomposition:
- Shared package:
  - state typedef {IDLE, CALC, RESP};
  - ID constants REQ0=0, REQ1=1;
  - default WIDTH and ADD_LAT constants.
- Sub-module rr_arbiter2: 2-way round-robin grant from (valid0, valid1, last_grant), combinational, one-hot grant output.

Test Plan:
- Reset, then req0 with a=0xFFFF_FFFF, b=0x0000_0001, cin=0 (ADD_LAT=1) -> add_start pulses in cycle 1; rsp_valid in cycle 2 with rsp_result=0x1_0000_0000, rsp_id=0.
- Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1, starting with 0 after reset. Each rsp_id matches; back-to-back responses are spaced ADD_LAT+2 cycles.
- rsp_ready held low for 10 cycles in RESP -> rsp_result stable, both req*_ready low throughout, no add_start; releasing rsp_ready -> IDLE one cycle later.
- ADD_LAT=3 with a mock registered adder; req1 a=5, b=7, cin=1 -> add_a, add_b, add_cin stable for 3 cycles; rsp_result=13 with rsp_id=1 in cycle 4.
- Only req1 valid while last_grant=1 -> req1 is still granted (no starvation by the pointer).
- Assert rst_n low mid-CALC -> all outputs 0 immediately; after release, a contested request goes to req0.
